// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 4:1 mux, with a fairness
// pointer and a per-grant hold limit so a busy owner cannot starve the others.
module mux4_rr_arbiter #(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = $clog2(HOLD_MAX)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       valid
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0] owner_nxt;
    logic [3:0] others;

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        onehot = 4'b0001 << idx;
    endfunction

    // First set bit of r scanning from p upwards (mod 4); lowest offset wins.
    function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        pick = p;
        for (int k = 3; k >= 0; k--) begin
            idx = p + 2'(k);
            if (r[idx]) pick = idx;
        end
    endfunction

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        owner_nxt = sel_q + 2'd1;
        others    = req & ~onehot(sel_q);

        case (state_q)
            IDLE: begin
                if (req != 4'b0000) begin
                    sel_d   = pick(req, ptr_q);
                    state_d = GRANT;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (!req[sel_q]) begin
                    ptr_d = owner_nxt;
                    cnt_d = '0;
                    if (req != 4'b0000) sel_d = pick(req, owner_nxt);
                    else                state_d = IDLE;
                end else if (cnt_q == CNT_W'(HOLD_MAX - 1)) begin
                    // Timed out: hand over only if someone else is waiting,
                    // otherwise the counter stays saturated.
                    if (others != 4'b0000) begin
                        sel_d = pick(others, owner_nxt);
                        ptr_d = owner_nxt;
                        cnt_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        gnt_d = (state_d == GRANT) ? onehot(sel_d) : 4'b0000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            sel_q   <= 2'd0;
            gnt_q   <= 4'b0000;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt   = gnt_q;
    assign sel   = sel_q;
    assign valid = |gnt_q;

endmodule
